// File: rtl/dma_copy_master_pkg.sv
// Shared definitions for the word-copy DMA master: FSM states, IO-region decode, word stride.
package dma_copy_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } dma_state_e;

    localparam logic [3:0]  IO_REGION  = 4'h4;
    localparam logic [31:0] WORD_BYTES = 32'd4;
    localparam logic [31:0] WORD_MASK  = 32'hFFFF_FFFC;

    // Peripheral space is selected by the top address nibble only.
    function automatic logic is_io(input logic [3:0] top_nibble);
        return top_nibble == IO_REGION;
    endfunction

endpackage

// File: rtl/dma_copy_master.sv
// Word-copy bus initiator: moves len 32-bit words from src_addr to dst_addr through the shared
// data-memory port, one read and one write per word, stalling whenever the arbiter withholds gnt.
module dma_copy_master
    import dma_copy_master_pkg::*;
#(
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             bus_req,
    input  logic             bus_gnt,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata
);

    dma_state_e       state_q, state_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [31:0]      buf_q, buf_d;
    logic             err_q, err_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        err_d     = err_q;
        busy      = 1'b0;
        done      = 1'b0;
        bus_req   = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_d   = src_addr & WORD_MASK;
                    dst_d   = dst_addr & WORD_MASK;
                    cnt_d   = len;
                    err_d   = 1'b0;
                    state_d = (len == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                busy     = 1'b1;
                bus_req  = 1'b1;
                mem_addr = src_q;
                // Both pointers are vetted before the read so no strobe ever reaches peripherals.
                if (is_io(src_q[31:28]) || is_io(dst_q[31:28])) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (bus_gnt) begin
                    mem_rd  = 1'b1;
                    buf_d   = mem_rdata;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                busy      = 1'b1;
                bus_req   = 1'b1;
                mem_addr  = dst_q;
                mem_wdata = buf_q;
                if (bus_gnt) begin
                    mem_wr  = 1'b1;
                    src_d   = src_q + WORD_BYTES;
                    dst_d   = dst_q + WORD_BYTES;
                    cnt_d   = cnt_q - LEN_W'(1);
                    state_d = (cnt_q == LEN_W'(1)) ? ST_DONE : ST_READ;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dma_copy_master.sv
// Self-checking bench for dma_copy_master: a word-array memory, a sequential copy reference model,
// directed scenarios plus randomized transfers under random grant.
module tb_dma_copy_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [7:0]  len;
    logic        busy, done, err, bus_req, bus_gnt, mem_rd, mem_wr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] ram  [256];
    logic [31:0] refm [256];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr[9:2]];

    dma_copy_master #(.LEN_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .bus_req   (bus_req),
        .bus_gnt   (bus_gnt),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: copy word by word in ascending order, stopping at the first IO-region pointer.
    task automatic model(input logic [31:0] s, input logic [31:0] d, input int n,
                         output int words, output logic xerr);
        logic [31:0] sa, da;
        words = 0;
        xerr  = 1'b0;
        for (int i = 0; i < n; i++) begin
            sa = (s & 32'hFFFF_FFFC) + 32'(4 * i);
            da = (d & 32'hFFFF_FFFC) + 32'(4 * i);
            if (sa[31:28] == 4'h4 || da[31:28] == 4'h4) begin
                xerr = 1'b1;
                break;
            end
            refm[da[9:2]] = refm[sa[9:2]];
            words++;
        end
    endtask

    function automatic int ram_diffs();
        int c = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== refm[i]) c++;
        return c;
    endfunction

    // mode 0: gnt high; 1: gnt low in cycles 2..4; 2: random gnt; 3: gnt high plus a stray start in cycle 3
    task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [7:0] n, input int mode,
                       output int done_cyc, output int busy_cnt, output int rd_cnt, output int wr_cnt,
                       output int bad_cnt, output logic [31:0] first_rd, output logic [31:0] first_wr);
        done_cyc = -1; busy_cnt = 0; rd_cnt = 0; wr_cnt = 0; bad_cnt = 0;
        first_rd = '0; first_wr = '0;
        src_addr = s; dst_addr = d; len = n; start = 1'b1; bus_gnt = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 2000; k++) begin
            case (mode)
                1: bus_gnt = !(k >= 2 && k <= 4);
                2: bus_gnt = ($urandom_range(0, 3) != 0);
                default: bus_gnt = 1'b1;
            endcase
            if (mode == 3 && k == 3) begin
                start = 1'b1; len = 8'd9; src_addr = 32'h100;
            end
            @(negedge clk);
            if (busy) busy_cnt++;
            if (bus_req !== busy) bad_cnt++;
            if ((mem_rd || mem_wr) && mem_addr[31:28] == 4'h4) bad_cnt++;
            if ((mem_rd || mem_wr) && !bus_gnt) bad_cnt++;
            if (mem_rd) begin
                if (rd_cnt == 0) first_rd = mem_addr;
                rd_cnt++;
            end
            if (mem_wr) begin
                if (wr_cnt == 0) first_wr = mem_addr;
                wr_cnt++;
                ram[mem_addr[9:2]] = mem_wdata;
            end
            if (done) begin
                done_cyc = k;
                break;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        @(posedge clk); #1;
        start = 1'b0;
        bus_gnt = 1'b1;
    endtask

    task automatic xfer(input string tag, input logic [31:0] s, input logic [31:0] d,
                        input logic [7:0] n, input int mode);
        int          words, exp_done, done_cyc, busy_cnt, rd_cnt, wr_cnt, bad_cnt;
        logic        xerr;
        logic [31:0] first_rd, first_wr;
        model(s, d, int'(n), words, xerr);
        run(s, d, n, mode, done_cyc, busy_cnt, rd_cnt, wr_cnt, bad_cnt, first_rd, first_wr);
        if (n == 0)  exp_done = 1;
        else if (xerr) exp_done = 2 * words + 2;
        else         exp_done = 2 * int'(n) + 1;
        if (mode == 1 && n != 0) exp_done += 3;
        if (mode != 2) chk({tag, "/done_cycle"}, 32'(done_cyc), 32'(exp_done));
        else           chk({tag, "/done_seen"}, 32'(done_cyc >= exp_done), 32'd1);
        chk({tag, "/busy_cycles"}, 32'(busy_cnt), 32'(done_cyc - 1));
        chk({tag, "/rd_count"}, 32'(rd_cnt), 32'(words));
        chk({tag, "/wr_count"}, 32'(wr_cnt), 32'(words));
        chk({tag, "/bad_strobes"}, 32'(bad_cnt), 32'd0);
        chk({tag, "/err"}, 32'(err), 32'(xerr));
        chk({tag, "/ram_diffs"}, 32'(ram_diffs()), 32'd0);
        if (words > 0) begin
            chk({tag, "/first_rd_addr"}, first_rd, s & 32'hFFFF_FFFC);
            chk({tag, "/first_wr_addr"}, first_wr, d & 32'hFFFF_FFFC);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "/flags"}, 32'({busy, done, err, bus_req, mem_rd, mem_wr}), 32'd0);
        chk({tag, "/mem_addr"}, mem_addr, 32'd0);
        chk({tag, "/mem_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        int strobes;
        reset = 1'b1; start = 1'b0; bus_gnt = 1'b1;
        src_addr = '0; dst_addr = '0; len = '0;
        for (int i = 0; i < 256; i++) begin
            ram[i]  = $urandom;
            refm[i] = ram[i];
        end
        for (int i = 0; i < 4; i++) begin
            ram[i]  = 32'hA0A0_0000 + 32'(i);
            refm[i] = ram[i];
        end
        #1;
        chk_quiet("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        xfer("copy4",   32'h0000_0000, 32'h0000_0040, 8'd4, 0);
        chk("copy4/ram16", ram[16], 32'hA0A0_0000);
        chk("copy4/ram19", ram[19], 32'hA0A0_0003);
        xfer("len0",    32'h0000_0010, 32'h0000_0080, 8'd0, 0);
        xfer("stall",   32'h0000_0020, 32'h0000_0060, 8'd2, 1);
        xfer("io",      32'h3FFF_FFF8, 32'h0000_0080, 8'd4, 0);
        xfer("unalign", 32'h0000_0013, 32'h0000_0022, 8'd2, 3);

        // Reset during the first WRITE cycle must kill the strobe at once and leave memory untouched.
        src_addr = 32'h200; dst_addr = 32'h300; len = 8'd3; start = 1'b1; bus_gnt = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid/in_write", 32'(mem_wr), 32'd1);
        #1 reset = 1'b1;
        #1 chk_quiet("rst_mid");
        @(negedge clk);
        reset = 1'b0;
        strobes = 0;
        repeat (3) begin
            @(negedge clk);
            if (mem_rd || mem_wr || busy) strobes++;
        end
        chk("rst_mid/idle_after", 32'(strobes), 32'd0);
        chk("rst_mid/ram_diffs", 32'(ram_diffs()), 32'd0);
        @(posedge clk); #1;
        xfer("post_rst", 32'h0000_0200, 32'h0000_0300, 8'd3, 0);

        for (int t = 0; t < 8; t++) begin
            logic [31:0] s, d;
            s = 32'($urandom_range(0, 255) * 4 + $urandom_range(0, 3));
            d = 32'($urandom_range(0, 255) * 4 + $urandom_range(0, 3));
            xfer($sformatf("rand%0d", t), s, d, 8'($urandom_range(0, 24)), 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
